// File: rtl/fwd_hazard_scoreboard_if.sv
// Decoder-side bundle for fwd_hazard_scoreboard: issue info and operand addresses in,
// bypass selects, stall and statistics out.
interface fwd_hazard_scoreboard_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int SELW    = 2
);
    // Flow control: pipe_en is the only advance qualifier. When high, the scoreboard shifts
    // on the clock edge; when low, every entry holds. stall/fwd_sel are always live.
    logic                      pipe_en;
    logic                      issue_valid;
    logic                      issue_we;
    logic                      issue_is_load;
    logic [REG_AW-1:0]         issue_rd;
    logic                      flush;
    logic [NUM_SRC*REG_AW-1:0] src_addr;
    logic [NUM_SRC-1:0]        src_used;
    logic [NUM_SRC*SELW-1:0]   fwd_sel;
    logic                      stall;
    logic [15:0]               stall_count;
    logic [15:0]               fwd_count;

    modport master (
        output pipe_en, issue_valid, issue_we, issue_is_load, issue_rd, flush, src_addr, src_used,
        input  fwd_sel, stall, stall_count, fwd_count
    );

    modport slave (
        input  pipe_en, issue_valid, issue_we, issue_is_load, issue_rd, flush, src_addr, src_used,
        output fwd_sel, stall, stall_count, fwd_count
    );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding select and load-use stall unit; tracks in-flight writers one entry per post-ID stage.
// Define FWD_STATS_EN to add saturating 16-bit stall/forward counters (tied to 0 otherwise).
module fwd_hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SELW     = $clog2(DEPTH + 1)
) (
    input logic                   clk,
    input logic                   rst,
    fwd_hazard_scoreboard_if.slave bus
);
    logic [DEPTH:1]    r_valid;
    logic [DEPTH:1]    r_is_load;
    logic [REG_AW-1:0] r_rd [1:DEPTH];

    logic                    w_insert;
    logic                    w_stall;
    logic [NUM_SRC-1:0]      w_not_ready;
    logic [NUM_SRC*SELW-1:0] w_fwd_sel;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [REG_AW-1:0] w_addr;
        logic              w_hit;
        logic              w_hit_pending;
        logic [SELW-1:0]   w_k;

        assign w_addr = bus.src_addr[gi*REG_AW +: REG_AW];

        // Scan oldest to youngest so the youngest producer is the last one to overwrite.
        always_comb begin
            w_hit         = 1'b0;
            w_hit_pending = 1'b0;
            w_k           = '0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (bus.src_used[gi] && (w_addr != '0) && r_valid[k] && (r_rd[k] == w_addr)) begin
                    w_hit         = 1'b1;
                    w_hit_pending = r_is_load[k] && (k <= LOAD_LAT);
                    w_k           = SELW'(k);
                end
            end
        end

        assign w_not_ready[gi]            = w_hit & w_hit_pending;
        assign w_fwd_sel[gi*SELW +: SELW] = (w_hit && !w_hit_pending) ? w_k : '0;
    end

    assign w_stall  = bus.issue_valid & ~bus.flush & (|w_not_ready);
    assign w_insert = bus.issue_valid & bus.issue_we & (bus.issue_rd != '0) & ~w_stall & ~bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= '0;
            r_is_load <= '0;
            for (int k = 1; k <= DEPTH; k++) r_rd[k] <= '0;
        end else if (bus.pipe_en) begin
            r_valid[1]   <= w_insert;
            r_is_load[1] <= w_insert & bus.issue_is_load;
            r_rd[1]      <= bus.issue_rd;
            for (int k = 2; k <= DEPTH; k++) begin
                r_valid[k]   <= r_valid[k-1];
                r_is_load[k] <= r_is_load[k-1];
                r_rd[k]      <= r_rd[k-1];
            end
        end
    end

    assign bus.fwd_sel = w_fwd_sel;
    assign bus.stall   = w_stall;

`ifdef FWD_STATS_EN
    logic [15:0] r_stall_count;
    logic [15:0] r_fwd_count;

    // One forward increment per issued instruction, regardless of how many operands bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
            r_fwd_count   <= '0;
        end else begin
            if (bus.pipe_en && w_stall && (r_stall_count != 16'hFFFF))
                r_stall_count <= r_stall_count + 16'd1;
            if (bus.pipe_en && bus.issue_valid && !w_stall && (|w_fwd_sel) && (r_fwd_count != 16'hFFFF))
                r_fwd_count <= r_fwd_count + 16'd1;
        end
    end

    assign bus.stall_count = r_stall_count;
    assign bus.fwd_count   = r_fwd_count;
`else
    assign bus.stall_count = '0;
    assign bus.fwd_count   = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Self-checking bench for fwd_hazard_scoreboard: default, deep (DEPTH=4/NUM_SRC=3/LOAD_LAT=2)
// and long-latency instances; counter expectations follow FWD_STATS_EN.
module tb_fwd_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef FWD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  logic [4:0] exp_q[$];
  logic [9:0] exp_b_q[$];

  fwd_hazard_scoreboard_if #(.REG_AW(5), .NUM_SRC(2), .SELW(2)) a_if ();
  fwd_hazard_scoreboard_if #(.REG_AW(5), .NUM_SRC(3), .SELW(3)) b_if ();
  fwd_hazard_scoreboard_if #(.REG_AW(5), .NUM_SRC(1), .SELW(6)) c_if ();

  fwd_hazard_scoreboard dut_a (.clk(clk), .rst(rst), .bus(a_if));
  fwd_hazard_scoreboard #(.REG_AW(5), .NUM_SRC(3), .DEPTH(4), .LOAD_LAT(2), .SELW(3))
    dut_b (.clk(clk), .rst(rst), .bus(b_if));
  fwd_hazard_scoreboard #(.REG_AW(5), .NUM_SRC(1), .DEPTH(32), .LOAD_LAT(31), .SELW(6))
    dut_c (.clk(clk), .rst(rst), .bus(c_if));

  typedef struct packed {
    logic       pe, iv, we, ld, fl;
    logic [4:0] rd, a0, a1;
    logic [1:0] used;
    logic       st;
    logic [1:0] s0, s1;
  } row_t;

  function automatic row_t mk(input int pe, iv, we, ld, fl, rd, a0, a1, used, st, s0, s1);
    row_t r;
    r.pe = pe[0]; r.iv = iv[0]; r.we = we[0]; r.ld = ld[0]; r.fl = fl[0];
    r.rd = rd[4:0]; r.a0 = a0[4:0]; r.a1 = a1[4:0]; r.used = used[1:0];
    r.st = st[0]; r.s0 = s0[1:0]; r.s1 = s1[1:0];
    return r;
  endfunction

  task automatic drive_a(input row_t r);
    @(negedge clk);
    a_if.pipe_en = r.pe; a_if.issue_valid = r.iv; a_if.issue_we = r.we;
    a_if.issue_is_load = r.ld; a_if.flush = r.fl; a_if.issue_rd = r.rd;
    a_if.src_addr = {r.a1, r.a0}; a_if.src_used = r.used;
    exp_q.push_back({r.st, r.s1, r.s0});
    #1;
  endtask

  task automatic idle_all();
    a_if.pipe_en = 1'b1; a_if.issue_valid = 1'b0; a_if.issue_we = 1'b0; a_if.issue_is_load = 1'b0;
    a_if.issue_rd = '0; a_if.flush = 1'b0; a_if.src_addr = '0; a_if.src_used = '0;
    b_if.pipe_en = 1'b1; b_if.issue_valid = 1'b0; b_if.issue_we = 1'b0; b_if.issue_is_load = 1'b0;
    b_if.issue_rd = '0; b_if.flush = 1'b0; b_if.src_addr = '0; b_if.src_used = '0;
    c_if.pipe_en = 1'b1; c_if.issue_valid = 1'b0; c_if.issue_we = 1'b0; c_if.issue_is_load = 1'b0;
    c_if.issue_rd = '0; c_if.flush = 1'b0; c_if.src_addr = '0; c_if.src_used = '0;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({a_if.stall, a_if.fwd_sel, a_if.stall_count, a_if.fwd_count} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_a: got stall=%b sel=%h sc=%h fc=%h, want all 0",
               a_if.stall, a_if.fwd_sel, a_if.stall_count, a_if.fwd_count);
    end
    n_cmp++;
    if ({b_if.stall, b_if.fwd_sel, c_if.stall, c_if.fwd_sel} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_bc: got b_stall=%b b_sel=%h c_stall=%b c_sel=%h, want all 0",
               b_if.stall, b_if.fwd_sel, c_if.stall, c_if.fwd_sel);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu_chain();
    row_t rows[$];
    logic [4:0] exp;
    repeat (3) rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 1, 0, 0, 8, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 8, 0, 1, 0, 1, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 8, 0, 1, 0, 2, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8, 2, 0, 0, 3));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 8, 8, 3, 0, 0, 0));
    foreach (rows[j]) begin
      drive_a(rows[j]);
      exp = exp_q.pop_front();
      n_cmp++;
      if ({a_if.stall, a_if.fwd_sel} !== exp) begin
        n_fail++;
        $display("FAIL alu_chain step %0d: got stall=%b sel=%h, want stall=%b sel=%h",
                 j, a_if.stall, a_if.fwd_sel, exp[4], exp[3:0]);
      end
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    logic [4:0] exp;
    repeat (3) rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 1, 1, 0, 9, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 9, 2, 1, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 9, 2, 0, 0, 2));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 9, 2, 0, 0, 3));
    foreach (rows[j]) begin
      drive_a(rows[j]);
      exp = exp_q.pop_front();
      n_cmp++;
      if ({a_if.stall, a_if.fwd_sel} !== exp) begin
        n_fail++;
        $display("FAIL load_use step %0d: got stall=%b sel=%h, want stall=%b sel=%h",
                 j, a_if.stall, a_if.fwd_sel, exp[4], exp[3:0]);
      end
    end
  endtask

  task automatic test_priority_r0();
    row_t rows[$];
    logic [4:0] exp;
    repeat (3) rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 5, 0, 1, 0, 1, 0));
    rows.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 5, 3, 0, 0, 3));
    foreach (rows[j]) begin
      drive_a(rows[j]);
      exp = exp_q.pop_front();
      n_cmp++;
      if ({a_if.stall, a_if.fwd_sel} !== exp) begin
        n_fail++;
        $display("FAIL priority_r0 step %0d: got stall=%b sel=%h, want stall=%b sel=%h",
                 j, a_if.stall, a_if.fwd_sel, exp[4], exp[3:0]);
      end
    end
  endtask

  task automatic test_freeze_flush();
    row_t rows[$];
    logic [4:0] exp;
    repeat (3) rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 1, 1, 0, 9, 0, 0, 0, 0, 0, 0));
    repeat (3) rows.push_back(mk(0, 1, 0, 0, 0, 0, 9, 0, 1, 1, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 9, 0, 1, 1, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 9, 0, 1, 0, 2, 0));
    repeat (3) rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 1, 1, 0, 9, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 1, 0, 1, 10, 9, 0, 1, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 10, 9, 3, 0, 0, 2));
    foreach (rows[j]) begin
      drive_a(rows[j]);
      exp = exp_q.pop_front();
      n_cmp++;
      if ({a_if.stall, a_if.fwd_sel} !== exp) begin
        n_fail++;
        $display("FAIL freeze_flush step %0d: got stall=%b sel=%h, want stall=%b sel=%h",
                 j, a_if.stall, a_if.fwd_sel, exp[4], exp[3:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    row_t rows[$];
    logic [4:0] exp;
    repeat (3) rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 1, 0, 0, 8, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 1, 1, 0, 9, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 8, 9, 3, 1, 2, 0));
    foreach (rows[j]) begin
      drive_a(rows[j]);
      exp = exp_q.pop_front();
      n_cmp++;
      if ({a_if.stall, a_if.fwd_sel} !== exp) begin
        n_fail++;
        $display("FAIL async_setup step %0d: got stall=%b sel=%h, want stall=%b sel=%h",
                 j, a_if.stall, a_if.fwd_sel, exp[4], exp[3:0]);
      end
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({a_if.stall, a_if.fwd_sel} !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset_out: got stall=%b sel=%h, want 0/0", a_if.stall, a_if.fwd_sel);
    end
    n_cmp++;
    if ({a_if.stall_count, a_if.fwd_count} !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset_cnt: got sc=%h fc=%h, want 0/0", a_if.stall_count, a_if.fwd_count);
    end
    #1 rst = 1'b0;
    drive_a(mk(1, 1, 0, 0, 0, 0, 8, 9, 3, 0, 0, 0));
    exp = exp_q.pop_front();
    n_cmp++;
    if ({a_if.stall, a_if.fwd_sel} !== exp) begin
      n_fail++;
      $display("FAIL async_after: got stall=%b sel=%h, want stall=%b sel=%h",
               a_if.stall, a_if.fwd_sel, exp[4], exp[3:0]);
    end
  endtask

  task automatic test_deep_load_use();
    logic [9:0]  exp;
    logic        st;
    logic [2:0]  s2;
    logic [15:0] exp_sc, exp_fc;
    for (int j = 0; j < 10; j++) begin
      st = (j == 5) || (j == 6);
      s2 = (j == 7) ? 3'd3 : (j == 8) ? 3'd4 : 3'd0;
      exp_b_q.push_back({st, s2, 6'd0});
      @(negedge clk);
      b_if.pipe_en = 1'b1;
      b_if.issue_valid = (j >= 4);
      b_if.issue_we = (j == 4);
      b_if.issue_is_load = (j == 4);
      b_if.issue_rd = 5'd9;
      b_if.src_addr = (j >= 5) ? {5'd9, 10'd0} : 15'd0;
      b_if.src_used = (j >= 5) ? 3'b100 : 3'b000;
      #1;
      exp = exp_b_q.pop_front();
      n_cmp++;
      if ({b_if.stall, b_if.fwd_sel} !== exp) begin
        n_fail++;
        $display("FAIL deep step %0d: got stall=%b sel=%h, want stall=%b sel=%h",
                 j, b_if.stall, b_if.fwd_sel, exp[9], exp[8:0]);
      end
      if (j == 7 || j == 9) begin
        exp_sc = STATS ? 16'd2 : 16'd0;
        exp_fc = (STATS && j == 9) ? 16'd2 : 16'd0;
        n_cmp++;
        if ({b_if.stall_count, b_if.fwd_count} !== {exp_sc, exp_fc}) begin
          n_fail++;
          $display("FAIL deep_counts step %0d: got sc=%0d fc=%0d, want sc=%0d fc=%0d",
                   j, b_if.stall_count, b_if.fwd_count, exp_sc, exp_fc);
        end
      end
    end
    b_if.issue_valid = 1'b0;
    b_if.src_used = '0;
  endtask

  task automatic test_stats_saturate();
    int n_cyc;
    int cp;
    int bad;
    int exp_sc;
    int exp_fc;
    bad = 0;
    n_cyc = STATS ? 67800 : 200;
    cp = STATS ? 1000 : 150;
    for (int j = 0; j < n_cyc; j++) begin
      @(negedge clk);
      c_if.pipe_en = 1'b1; c_if.issue_valid = 1'b1; c_if.issue_we = 1'b1;
      c_if.issue_is_load = 1'b1; c_if.issue_rd = 5'd9; c_if.src_addr = 5'd9; c_if.src_used = 1'b1;
      #1;
      if (c_if.stall !== ((j % 32) != 0)) bad++;
      if (j == cp) begin
        exp_sc = STATS ? (cp - (cp + 31) / 32) : 0;
        exp_fc = STATS ? ((cp - 1) / 32) : 0;
        n_cmp++;
        if ({c_if.stall_count, c_if.fwd_count} !== {exp_sc[15:0], exp_fc[15:0]}) begin
          n_fail++;
          $display("FAIL stats_midway: got sc=%0d fc=%0d, want sc=%0d fc=%0d",
                   c_if.stall_count, c_if.fwd_count, exp_sc, exp_fc);
        end
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_pattern: %0d cycles off, want 0", bad);
    end
    @(negedge clk);
    c_if.pipe_en = 1'b0;
    #1;
    exp_sc = n_cyc - (n_cyc + 31) / 32;
    if (exp_sc > 65535) exp_sc = 65535;
    if (!STATS) exp_sc = 0;
    n_cmp++;
    if (c_if.stall_count !== exp_sc[15:0]) begin
      n_fail++;
      $display("FAIL stats_saturate: got sc=%h, want %h", c_if.stall_count, exp_sc[15:0]);
    end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_priority_r0();
    test_freeze_flush();
    test_async_reset();
    test_deep_load_use();
    test_stats_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
